// File: rtl/conway_vga_render.sv
// conway_vga_render
// Display-side reader for the Game of Life grid. It generates VGA timing and
// takes one snapshot of the packed grid per frame during vertical blanking.
// Each cell is drawn as an 8x8 block inside a 256x256 window, and the block
// emits a generation strobe every FRAMES_PER_STEP frames.
// The line and frame geometry is parameterised. The defaults are standard
// 640x480@60 timing.
module conway_vga_render #(
    parameter int          FRAMES_PER_STEP = 30,
    parameter int          X_OFF           = 192,
    parameter int          Y_OFF           = 112,
    parameter logic [11:0] ALIVE_RGB       = 12'hFFF,
    parameter logic [11:0] DEAD_RGB        = 12'h000,
    parameter logic [11:0] BG_RGB          = 12'h008,
    parameter int          H_ACTIVE        = 640,
    parameter int          H_FP            = 16,
    parameter int          H_SYNC          = 96,
    parameter int          H_BP            = 48,
    parameter int          V_ACTIVE        = 480,
    parameter int          V_FP            = 10,
    parameter int          V_SYNC          = 2,
    parameter int          V_BP            = 33
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [1023:0] grid_pack,
    output logic          hsync_n,
    output logic          vsync_n,
    output logic          video_on,
    output logic [11:0]   rgb,
    output logic          step
);

    // Timing boundaries are held at 11 bits so that the window end can be
    // represented, even when it lies past the end of a line.
    localparam logic [10:0] L_H_ACT    = 11'(H_ACTIVE);
    localparam logic [10:0] L_H_SS     = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] L_H_SE     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] L_H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] L_V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] L_V_SS     = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] L_V_SE     = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [10:0] L_V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] L_X0       = 11'(X_OFF);
    localparam logic [10:0] L_X1       = 11'(X_OFF + 256);
    localparam logic [10:0] L_Y0       = 11'(Y_OFF);
    localparam logic [10:0] L_Y1       = 11'(Y_OFF + 256);
    localparam logic [9:0]  L_X0_10    = 10'(X_OFF);
    localparam logic [9:0]  L_Y0_10    = 10'(Y_OFF);
    localparam logic [7:0]  L_FPS_LAST = 8'(FRAMES_PER_STEP - 1);

    logic [9:0]    r_hcnt;
    logic [9:0]    r_vcnt;
    logic [7:0]    r_frame;
    logic [1023:0] r_snap;

    logic [10:0]   w_h;
    logic [10:0]   w_v;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_active;
    logic          w_hsync_n;
    logic          w_vsync_n;
    logic          w_in_win;
    logic          w_capture;
    logic [4:0]    w_col;
    logic [4:0]    w_row;
    logic [9:0]    w_idx;
    logic          w_cell;
    logic [11:0]   w_rgb;

    assign w_h       = {1'b0, r_hcnt};
    assign w_v       = {1'b0, r_vcnt};
    assign w_h_last  = (w_h == L_H_LAST);
    assign w_v_last  = (w_v == L_V_LAST);
    assign w_active  = (w_h < L_H_ACT) && (w_v < L_V_ACT);
    assign w_hsync_n = !((w_h >= L_H_SS) && (w_h < L_H_SE));
    assign w_vsync_n = !((w_v >= L_V_SS) && (w_v < L_V_SE));
    assign w_in_win  = (w_h >= L_X0) && (w_h < L_X1) && (w_v >= L_Y0) && (w_v < L_Y1);

    // This is the first blanking line, so the snapshot load can never tear a
    // visible frame.
    assign w_capture = (r_hcnt == 10'd0) && (w_v == L_V_ACT);

    // Cell address. The screen row is flipped because grid row 0 is the bottom
    // of the board but is drawn last.
    assign w_col = 5'((r_hcnt - L_X0_10) >> 3);
    assign w_row = ~5'((r_vcnt - L_Y0_10) >> 3);
    assign w_idx = {w_row, w_col};
    assign w_cell = r_snap[w_idx];

    // Select the pixel colour: blank, background, or cell state.
    always_comb begin
        w_rgb = 12'h000;
        if (w_active) begin
            if (w_in_win) begin
                w_rgb = w_cell ? ALIVE_RGB : DEAD_RGB;
            end else begin
                w_rgb = BG_RGB;
            end
        end
    end

    // Raster position: hcnt wraps every line, and vcnt advances on each hcnt wrap.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hcnt <= 10'd0;
            r_vcnt <= 10'd0;
        end else if (w_h_last) begin
            r_hcnt <= 10'd0;
            r_vcnt <= w_v_last ? 10'd0 : r_vcnt + 10'd1;
        end else begin
            r_hcnt <= r_hcnt + 10'd1;
        end
    end

    // Once per frame: take the grid snapshot and advance the generation cadence.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_snap  <= '0;
            r_frame <= 8'd0;
            step    <= 1'b0;
        end else begin
            step <= 1'b0;
            if (w_capture) begin
                r_snap <= grid_pack;
                if (r_frame == L_FPS_LAST) begin
                    r_frame <= 8'd0;
                    step    <= 1'b1;
                end else begin
                    r_frame <= r_frame + 8'd1;
                end
            end
        end
    end

    // Register the video outputs so they all lag the raster position by one clock.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hsync_n  <= 1'b1;
            vsync_n  <= 1'b1;
            video_on <= 1'b0;
            rgb      <= 12'h000;
        end else begin
            hsync_n  <= w_hsync_n;
            vsync_n  <= w_vsync_n;
            video_on <= w_active;
            rgb      <= w_rgb;
        end
    end

endmodule

// File: tb/tb_conway_vga_render.sv
// tb_conway_vga_render
// u_full uses the default 640x480 geometry and covers reset and horizontal
// timing. u_dut uses a reduced raster (60x32 clocks per frame), so that
// multi-frame behaviour fits in a short run:
//   H: 40 active, 4 fp, 8 sync, 8 bp   -> hsync low at h 44..51
//   V: 24 active, 2 fp, 2 sync, 4 bp   -> vsync low at v 26..27, capture at (0,24)
//   Window origin (8,4), which is clipped by the small active area.
//   FRAMES_PER_STEP = 2.
module tb_conway_vga_render;

    logic          clk = 1'b0;
    logic          resetn;
    logic [1023:0] grid_full;
    logic [1023:0] grid_small;

    logic          hs_f, vs_f, von_f, step_f;
    logic [11:0]   rgb_f;
    logic          hs_s, vs_s, von_s, step_s;
    logic [11:0]   rgb_s;

    int checks = 0;
    int errors = 0;
    int k = 0;

    always #5 clk = ~clk;

    conway_vga_render u_full (
        .clk      (clk),
        .resetn   (resetn),
        .grid_pack(grid_full),
        .hsync_n  (hs_f),
        .vsync_n  (vs_f),
        .video_on (von_f),
        .rgb      (rgb_f),
        .step     (step_f)
    );

    conway_vga_render #(
        .FRAMES_PER_STEP(2),
        .X_OFF(8), .Y_OFF(4),
        .H_ACTIVE(40), .H_FP(4), .H_SYNC(8), .H_BP(8),
        .V_ACTIVE(24), .V_FP(2), .V_SYNC(2), .V_BP(4)
    ) u_dut (
        .clk      (clk),
        .resetn   (resetn),
        .grid_pack(grid_small),
        .hsync_n  (hs_s),
        .vsync_n  (vs_s),
        .video_on (von_s),
        .rgb      (rgb_s),
        .step     (step_s)
    );

    // The counter state shown on u_dut's outputs after k sampled clocks
    // since reset release.
    function automatic int st_h();
        return (k - 1) % 60;
    endfunction

    function automatic int st_v();
        return ((k - 1) / 60) % 32;
    endfunction

    task automatic tick();
        @(negedge clk);
        k++;
    endtask

    task automatic wait_state(input int h, input int v);
        int n;
        bit found;
        n = 0;
        found = 0;
        while (!found && n < 4000) begin
            tick();
            n++;
            if (st_h() == h && st_v() == v) found = 1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_state(%0d,%0d): not reached within %0d clocks", h, v, n);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (hs_f !== 1'b1 || vs_f !== 1'b1) begin errors++; $display("FAIL reset_sync_full: got %b%b expected 11", hs_f, vs_f); end
        checks++; if (von_f !== 1'b0 || step_f !== 1'b0) begin errors++; $display("FAIL reset_von_step_full: got %b%b expected 00", von_f, step_f); end
        checks++; if (rgb_f !== 12'h000) begin errors++; $display("FAIL reset_rgb_full: got %h expected 000", rgb_f); end
        checks++; if (hs_s !== 1'b1 || vs_s !== 1'b1) begin errors++; $display("FAIL reset_sync_small: got %b%b expected 11", hs_s, vs_s); end
        checks++; if (von_s !== 1'b0 || step_s !== 1'b0) begin errors++; $display("FAIL reset_von_step_small: got %b%b expected 00", von_s, step_s); end
        checks++; if (rgb_s !== 12'h000) begin errors++; $display("FAIL reset_rgb_small: got %h expected 000", rgb_s); end
        @(negedge clk);
        resetn = 1'b1;
        k = 0;
    endtask

    task automatic test_hsync_full();
        int fall[3] = '{default: 0};
        int nf = 0;
        int rise0 = -1;
        int vs_bad = 0;
        logic prev = 1'b1;
        for (int n = 0; n < 2300; n++) begin
            tick();
            if (prev && !hs_f && nf < 3) begin fall[nf] = k; nf++; end
            if (!prev && hs_f && rise0 < 0) rise0 = k;
            prev = hs_f;
            if (vs_f !== 1'b1) vs_bad++;
            if (k == 1) begin
                checks++; if (rgb_f !== 12'h008) begin errors++; $display("FAIL full_rgb_at_0_0: got %h expected 008", rgb_f); end
                checks++; if (von_f !== 1'b1) begin errors++; $display("FAIL full_von_at_0_0: got %b expected 1", von_f); end
            end
            if (k == 640) begin
                checks++; if (von_f !== 1'b1) begin errors++; $display("FAIL full_von_h639: got %b expected 1", von_f); end
            end
            if (k == 641) begin
                checks++; if (von_f !== 1'b0) begin errors++; $display("FAIL full_von_h640: got %b expected 0", von_f); end
            end
        end
        checks++; if (nf != 3) begin errors++; $display("FAIL hsync_fall_count: got %0d expected 3", nf); end
        checks++; if (fall[0] != 657) begin errors++; $display("FAIL hsync_first_fall: got %0d expected 657", fall[0]); end
        checks++; if (rise0 - fall[0] != 96) begin errors++; $display("FAIL hsync_width: got %0d expected 96", rise0 - fall[0]); end
        checks++; if (fall[1] - fall[0] != 800 || fall[2] - fall[1] != 800) begin errors++; $display("FAIL hsync_period: got %0d/%0d expected 800", fall[1] - fall[0], fall[2] - fall[1]); end
        checks++; if (vs_bad != 0) begin errors++; $display("FAIL full_vsync_early: got %0d low clocks expected 0", vs_bad); end
    endtask

    task automatic test_vtiming();
        int f0 = -1, f1 = -1, r0 = -1, fh = -1, fv = -1;
        int von_cnt = 0, von_bad = 0;
        logic prev;
        wait_state(0, 0);
        prev = vs_s;
        for (int n = 0; n < 3840; n++) begin
            tick();
            if (prev && !vs_s) begin
                if (f0 < 0) begin f0 = k; fh = st_h(); fv = st_v(); end
                else if (f1 < 0) f1 = k;
            end
            if (!prev && vs_s && f0 >= 0 && r0 < 0) r0 = k;
            prev = vs_s;
            if (n < 1920 && von_s === 1'b1) von_cnt++;
            if (von_s !== 1'b0 && (st_v() >= 24 || st_h() >= 40)) von_bad++;
        end
        checks++; if (fh != 0 || fv != 26) begin errors++; $display("FAIL vsync_fall_pos: got (%0d,%0d) expected (0,26)", fh, fv); end
        checks++; if (r0 - f0 != 120) begin errors++; $display("FAIL vsync_width: got %0d expected 120", r0 - f0); end
        checks++; if (f1 - f0 != 1920) begin errors++; $display("FAIL vsync_period: got %0d expected 1920", f1 - f0); end
        checks++; if (von_cnt != 960) begin errors++; $display("FAIL video_on_count: got %0d expected 960", von_cnt); end
        checks++; if (von_bad != 0) begin errors++; $display("FAIL video_on_blank: got %0d expected 0", von_bad); end
    endtask

    task automatic test_pixel_map();
        int ph[8] = '{8, 15, 16, 8, 7, 0, 45, 10};
        int pv[8] = '{4, 11, 4, 12, 4, 0, 5, 25};
        logic [11:0] pe[8] = '{12'hFFF, 12'hFFF, 12'h000, 12'h000, 12'h008, 12'h008, 12'h000, 12'h000};
        int bad = 0;
        int h, v;
        logic [11:0] e;
        grid_small = '0;
        grid_small[31*32+0] = 1'b1;
        wait_state(0, 24);
        for (int n = 0; n < 1920; n++) begin
            tick();
            h = st_h();
            v = st_v();
            if (h >= 40 || v >= 24) e = 12'h000;
            else if (h >= 8 && h < 16 && v >= 4 && v < 12) e = 12'hFFF;
            else if (h >= 8 && v >= 4) e = 12'h000;
            else e = 12'h008;
            if (rgb_s !== e) bad++;
            for (int p = 0; p < 8; p++) begin
                if (h == ph[p] && v == pv[p]) begin
                    checks++;
                    if (rgb_s !== pe[p]) begin errors++; $display("FAIL pixel(%0d,%0d): got %h expected %h", h, v, rgb_s, pe[p]); end
                end
            end
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL pixel_scan: got %0d wrong pixels expected 0", bad); end
    endtask

    task automatic test_tear_free();
        wait_state(0, 6);
        grid_small = '0;
        grid_small[29*32+3] = 1'b1;
        wait_state(12, 9);
        checks++; if (rgb_s !== 12'hFFF) begin errors++; $display("FAIL tear_old_cell: got %h expected FFF", rgb_s); end
        wait_state(32, 20);
        checks++; if (rgb_s !== 12'h000) begin errors++; $display("FAIL tear_new_cell_early: got %h expected 000", rgb_s); end
        wait_state(12, 9);
        checks++; if (rgb_s !== 12'h000) begin errors++; $display("FAIL tear_old_cell_cleared: got %h expected 000", rgb_s); end
        wait_state(32, 20);
        checks++; if (rgb_s !== 12'hFFF) begin errors++; $display("FAIL tear_new_cell_shown: got %h expected FFF", rgb_s); end
        wait_state(39, 23);
        checks++; if (rgb_s !== 12'hFFF) begin errors++; $display("FAIL tear_new_cell_corner: got %h expected FFF", rgb_s); end
    endtask

    task automatic test_step_cadence();
        int p0 = -1, p1 = -1, np = 0;
        int pos_bad = 0, wide = 0, snap_bad = 0;
        logic prev = 1'b0;
        wait_state(0, 0);
        for (int n = 0; n < 7680; n++) begin
            tick();
            if (st_h() == 0 && st_v() == 10) grid_small = {32{32'(k)}};
            if (st_h() == 59 && st_v() == 23 && u_dut.r_snap === grid_small) snap_bad++;
            if (st_h() == 0 && st_v() == 24 && u_dut.r_snap !== grid_small) snap_bad++;
            if (step_s === 1'b1) begin
                np++;
                if (p0 < 0) p0 = k; else if (p1 < 0) p1 = k;
                if (st_h() != 0 || st_v() != 24) pos_bad++;
                if (prev) wide++;
            end
            prev = step_s;
        end
        checks++; if (np != 2) begin errors++; $display("FAIL step_count: got %0d expected 2", np); end
        checks++; if (p1 - p0 != 3840) begin errors++; $display("FAIL step_period: got %0d expected 3840", p1 - p0); end
        checks++; if (pos_bad != 0) begin errors++; $display("FAIL step_position: got %0d off-capture pulses expected 0", pos_bad); end
        checks++; if (wide != 0) begin errors++; $display("FAIL step_width: got %0d extra high clocks expected 0", wide); end
        checks++; if (snap_bad != 0) begin errors++; $display("FAIL snap_capture: got %0d bad samples expected 0", snap_bad); end
    endtask

    task automatic test_reset_midframe();
        int n;
        grid_small = '0;
        grid_small[31*32+0] = 1'b1;
        wait_state(30, 10);
        resetn = 1'b0;
        #1;
        checks++; if (rgb_s !== 12'h000 || von_s !== 1'b0) begin errors++; $display("FAIL midreset_video: got rgb=%h von=%b expected 000/0", rgb_s, von_s); end
        checks++; if (hs_s !== 1'b1 || vs_s !== 1'b1 || step_s !== 1'b0) begin errors++; $display("FAIL midreset_sync: got %b%b%b expected 110", hs_s, vs_s, step_s); end
        checks++; if (u_dut.r_hcnt !== 10'd0 || u_dut.r_vcnt !== 10'd0) begin errors++; $display("FAIL midreset_counters: got (%0d,%0d) expected (0,0)", u_dut.r_hcnt, u_dut.r_vcnt); end
        checks++; if (u_dut.r_snap !== '0) begin errors++; $display("FAIL midreset_snap: got nonzero expected 0"); end
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        k = 0;
        tick();
        checks++; if (rgb_s !== 12'h008 || von_s !== 1'b1) begin errors++; $display("FAIL midreset_restart: got rgb=%h von=%b expected 008/1", rgb_s, von_s); end
        n = 0;
        while (hs_s !== 1'b0 && n < 200) begin tick(); n++; end
        checks++; if (k != 45) begin errors++; $display("FAIL midreset_hsync_fall: got %0d expected 45", k); end
        wait_state(8, 4);
        checks++; if (rgb_s !== 12'h000) begin errors++; $display("FAIL midreset_dead_window: got %h expected 000", rgb_s); end
        wait_state(8, 4);
        checks++; if (rgb_s !== 12'hFFF) begin errors++; $display("FAIL midreset_after_capture: got %h expected FFF", rgb_s); end
    endtask

    initial begin
        grid_full  = '0;
        grid_small = '0;
        test_reset();
        test_hsync_full();
        test_vtiming();
        test_pixel_map();
        test_tear_free();
        test_step_cadence();
        test_reset_midframe();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish within 90000 clocks");
        $fatal(1);
    end

endmodule
